// File: rtl/lsu_mem_ctrl_if.sv
// Word-organised data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: validates RV32I load/store requests, drives the memory handshake
// and returns lane-extracted, sign/zero-extended load data on ReadData.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU_result,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [1:0]  ErrCode,
    lsu_mem_ctrl_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} lsuState_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    lsuState_t     stateReg;
    logic [CW-1:0] waitCnt;
    logic          isLoadReg;
    logic [2:0]    f3Reg;
    logic [1:0]    offReg;

    logic          f3Legal;
    logic          misaligned;
    logic [3:0]    beNext;
    logic [31:0]   wdataNext;

    logic [7:0]    rdByte [4];
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;
    logic [31:0]   loadData;

    // Request decode works on the live inputs; the result is captured on acceptance.
    always_comb begin
        f3Legal    = MemRead ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned = 1'b0;
        beNext     = 4'b1111;
        wdataNext  = WriteData;
        case (funct3[1:0])
            2'b00: begin
                beNext    = 4'b0001 << ALU_result[1:0];
                wdataNext = {4{WriteData[7:0]}};
            end
            2'b01: begin
                misaligned = ALU_result[0];
                beNext     = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdataNext  = {2{WriteData[15:0]}};
            end
            2'b10: misaligned = |ALU_result[1:0];
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rdByte[gi] = mem.mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byteSel = rdByte[offReg];
    assign halfSel = offReg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        case (f3Reg)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b100:  loadData = {24'd0, byteSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg      <= IDLE;
            waitCnt       <= '0;
            isLoadReg     <= 1'b0;
            f3Reg         <= 3'b000;
            offReg        <= 2'b00;
            ReadData      <= 32'd0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Err           <= 1'b0;
            ErrCode       <= 2'b00;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= 32'd0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        isLoadReg     <= MemRead;
                        f3Reg         <= funct3;
                        offReg        <= ALU_result[1:0];
                        mem.mem_addr  <= {ALU_result[31:2], 2'b00};
                        mem.mem_wdata <= wdataNext;
                        waitCnt       <= '0;
                        ErrCode       <= 2'b00;
                        // Illegal width code outranks misalignment.
                        if (!f3Legal) begin
                            stateReg <= RESP;
                            Done     <= 1'b1;
                            Err      <= 1'b1;
                            ErrCode  <= 2'b10;
                        end else if (misaligned) begin
                            stateReg <= RESP;
                            Done     <= 1'b1;
                            Err      <= 1'b1;
                            ErrCode  <= 2'b01;
                        end else begin
                            stateReg    <= REQ;
                            Busy        <= 1'b1;
                            mem.mem_req <= 1'b1;
                            mem.mem_we  <= ~MemRead;
                            mem.mem_be  <= beNext;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready || (TIMEOUT_CYCLES > 0 && waitCnt == LAST_WAIT)) begin
                        stateReg    <= RESP;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        mem.mem_be  <= 4'b0000;
                        if (mem.mem_ready) begin
                            if (isLoadReg) begin
                                ReadData <= loadData;
                            end
                        end else begin
                            Err     <= 1'b1;
                            ErrCode <= 2'b11;
                        end
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                RESP: begin
                    stateReg <= IDLE;
                    Done     <= 1'b0;
                    Err      <= 1'b0;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized transactions
// checked against a reference model derived from the load/store rules.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALU_result, WriteData;
    logic [31:0] ReadData;
    logic        Busy, Done, Err;
    logic [1:0]  ErrCode;

    lsu_mem_ctrl_if memIf ();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALU_result (ALU_result),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .ErrCode    (ErrCode),
        .mem        (memIf.master)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] expRd   = 32'd0;
    logic [1:0]  lastErr = 2'b00;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (rdata >> (8 * (addr[1:0] & 2'b10))) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // One transaction: drive a request, play the memory with the given ready delay, check all.
    task automatic doTxn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int delay);
        bit          isLoad, legal, mis;
        int          nb, lane, expLat, expReq, doneCyc, reqCycles;
        logic [1:0]  expErr;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        isLoad = rd;
        nb     = 1 << f3[1:0];
        legal  = isLoad ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        mis    = legal && ((addr % nb) != 0);
        lane   = legal ? (int'(addr[1:0]) & (4 - nb)) : 0;
        expBe  = 4'(((1 << nb) - 1) << lane);
        expWd  = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        expErr = !legal ? 2'b10 : mis ? 2'b01 : (delay >= 16) ? 2'b11 : 2'b00;
        expLat = (expErr == 2'b10 || expErr == 2'b01) ? 1 : (expErr == 2'b11) ? 17 : delay + 2;
        expReq = (expErr == 2'b10 || expErr == 2'b01) ? 0 : (expErr == 2'b11) ? 16 : delay + 1;

        @(negedge clk);
        checkVal("idle_done", 32'(Done), 32'd0);
        checkVal("idle_busy", 32'(Busy), 32'd0);
        checkVal("idle_be", 32'(memIf.mem_be), 32'd0);
        checkVal("idle_errcode_hold", 32'(ErrCode), 32'(lastErr));
        MemRead = rd; MemWrite = wr; funct3 = f3; ALU_result = addr; WriteData = wd;
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'($urandom); ALU_result = $urandom; WriteData = $urandom;

        doneCyc = 0; reqCycles = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            memIf.mem_ready = 1'b0;
            if (memIf.mem_req) begin
                reqCycles++;
                checkVal("req_addr", memIf.mem_addr, {addr[31:2], 2'b00});
                checkVal("req_be", 32'(memIf.mem_be), 32'(expBe));
                checkVal("req_we", 32'(memIf.mem_we), 32'(!isLoad));
                checkVal("req_busy", 32'(Busy), 32'd1);
                if (!isLoad) checkVal("req_wdata", memIf.mem_wdata, expWd);
                if (reqCycles == delay + 1) begin
                    memIf.mem_ready = 1'b1;
                    memIf.mem_rdata = rdata;
                end else begin
                    memIf.mem_rdata = $urandom;
                end
            end
            if (Done) begin
                doneCyc = cyc;
                break;
            end
        end
        memIf.mem_ready = 1'b0;
        if (expErr == 2'b00 && isLoad) expRd = refLoad(f3, addr, rdata);
        checkVal("done_latency", 32'(doneCyc), 32'(expLat));
        checkVal("req_cycles", 32'(reqCycles), 32'(expReq));
        checkVal("err", 32'(Err), 32'(expErr != 2'b00));
        checkVal("errcode", 32'(ErrCode), 32'(expErr));
        checkVal("done_busy", 32'(Busy), 32'd0);
        checkVal("readdata", ReadData, expRd);
        lastErr = expErr;
        $display("txn rd=%0d wr=%0d f3=%0d addr=0x%08h wd=0x%08h delay=%0d -> err=%0d ReadData=0x%08h",
                 rd, wr, f3, addr, wd, delay, ErrCode, ReadData);
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
        ALU_result = 32'd0; WriteData = 32'd0;
        memIf.mem_ready = 1'b0; memIf.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checkVal("rst_req", 32'(memIf.mem_req), 32'd0);
        checkVal("rst_we", 32'(memIf.mem_we), 32'd0);
        checkVal("rst_be", 32'(memIf.mem_be), 32'd0);
        checkVal("rst_done", 32'(Done), 32'd0);
        checkVal("rst_err", 32'({Err, ErrCode}), 32'd0);
        checkVal("rst_busy", 32'(Busy), 32'd0);
        checkVal("rst_readdata", ReadData, 32'd0);
        rst = 1'b0;

        doTxn(1, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        checkVal("lw_literal", ReadData, 32'hDEADBEEF);
        doTxn(1, 0, 3'd0, 32'h13, 32'h0, 32'h80FF7F01, 1);
        checkVal("lb_literal", ReadData, 32'hFFFFFF80);
        doTxn(1, 0, 3'd4, 32'h13, 32'h0, 32'h80FF7F01, 0);
        checkVal("lbu_literal", ReadData, 32'h00000080);
        doTxn(1, 0, 3'd1, 32'h12, 32'h0, 32'h80FF7F01, 2);
        checkVal("lh_literal", ReadData, 32'hFFFF80FF);
        doTxn(1, 0, 3'd5, 32'h12, 32'h0, 32'h80FF7F01, 0);
        checkVal("lhu_literal", ReadData, 32'h000080FF);
        doTxn(0, 1, 3'd0, 32'h21, 32'h123456AB, 32'h0, 3);
        doTxn(0, 1, 3'd1, 32'h22, 32'h123456AB, 32'h0, 3);
        checkVal("store_keeps_rd", ReadData, 32'h000080FF);
        doTxn(1, 0, 3'd2, 32'h06, 32'h0, 32'h0, 0);
        doTxn(1, 0, 3'd3, 32'h10, 32'h0, 32'h0, 0);
        doTxn(0, 1, 3'd3, 32'h05, 32'h0, 32'h0, 0);
        doTxn(1, 0, 3'd2, 32'h10, 32'h0, 32'h11111111, 20);
        doTxn(1, 0, 3'd2, 32'h10, 32'h0, 32'h22222222, 1);
        doTxn(1, 1, 3'd2, 32'h44, 32'hCAFEF00D, 32'h33333333, 0);

        // Reset landing on the second REQ cycle drops the transaction.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'd2; ALU_result = 32'h40;
        @(posedge clk);
        #1 MemRead = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("midrst_req", 32'(memIf.mem_req), 32'd0);
        checkVal("midrst_busy", 32'(Busy), 32'd0);
        checkVal("midrst_readdata", ReadData, 32'd0);
        checkVal("midrst_done", 32'(Done), 32'd0);
        expRd = 32'd0; lastErr = 2'b00;
        repeat (3) begin
            @(negedge clk);
            checkVal("midrst_no_done", 32'(Done), 32'd0);
        end

        for (int i = 0; i < 150; i++) begin
            int   sel;
            bit   rd, wr;
            int   dly;
            sel = $urandom_range(0, 9);
            rd  = (sel < 5) || (sel == 9);
            wr  = (sel >= 5);
            dly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            doTxn(rd, wr, 3'($urandom), 32'h100 + $urandom_range(0, 255), $urandom, $urandom, dly);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit: the memory-side producer of ReadData, which feeds the writeback result mux.
- Accepts a load or store request from the control path and uses ALU_result as the byte address.
- Runs a req/ready handshake with word-organised data memory.
- For loads, returns a byte-lane-extracted, sign- or zero-extended word on ReadData, plus a one-cycle Done pulse.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ready before aborting; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRead  input  1  load request; sampled only in IDLE.
- MemWrite  input  1  store request; sampled only in IDLE.
- funct3  input  3  RV32I width/sign code.
- ALU_result  input  32  byte address.
- WriteData  input  32  store data (rs2).
- ReadData  output  32  registered load result.
- Busy  output  1  high while a request is in REQ.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  one-cycle pulse, coincident with Done, when the access failed.
- ErrCode  output  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 otherwise.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word address: {addr[31:2], 2'b00}.
- mem_be  output  4  byte enables; bit i = byte lane i.
- mem_wdata  output  32  lane-replicated store data.
- mem_ready  input  1  memory accepts / returns data this cycle.
- mem_rdata  input  32  read word; valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset (synchronous, any state): state=IDLE; all outputs 0; ReadData=0; timeout counter=0.
- State IDLE:
  - If MemRead or MemWrite is high, latch funct3, the address, WriteData and the op. MemRead has priority when both are high.
  - Validate the latched request:
    - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Legal stores: 000 SB, 001 SH, 010 SW.
    - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Illegal funct3 -> RESP with ErrCode=10; no memory request. Illegal funct3 takes precedence over misalignment.
  - Misaligned -> RESP with ErrCode=01; no memory request.
  - Otherwise -> REQ.
- State REQ:
  - mem_req=1 and Busy=1.
  - mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ready is sampled high.
  - Each cycle with mem_ready=0 increments the counter.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, go to RESP with ErrCode=11; ReadData is unchanged.
  - On mem_ready=1: for a load, register the extracted data into ReadData; go to RESP. mem_req falls on the next cycle.
  - Minimum latency, acceptance edge to Done high: 2 cycles when mem_ready is high on the first REQ cycle.
- State RESP:
  - Done=1 for exactly one cycle. Err=1 iff ErrCode!=00. Busy=0.
  - Return to IDLE. MemRead/MemWrite are ignored in RESP.
  - ErrCode holds until the next acceptance, then clears to 00.
- Store lane rules:
  - SB: be=0001<<addr[1:0]; wdata={4{WriteData[7:0]}}.
  - SH: be=addr[1]?1100:0011; wdata={2{WriteData[15:0]}}.
  - SW: be=1111; wdata=WriteData.
- Load lane rules (o = latched addr[1:0]):
  - LB/LBU: byte = mem_rdata[8*o+7:8*o].
  - LH/LHU: half = mem_rdata[16*o[1]+15:16*o[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_be=0000 and mem_we=0 outside REQ.
- ReadData changes only on a successful load completion; stores and errors leave it unchanged.
- Reset asserted during REQ: mem_req is low on the cycle after the reset edge; the transaction is dropped with no Done pulse.
- Request held high across RESP: it is re-accepted in the following IDLE cycle as a new transaction.

Test Plan:
- LW: addr 0x00000010, mem_ready high one cycle after mem_req -> mem_addr=0x10, be=1111, we=0; mem_rdata=0xDEADBEEF -> ReadData=0xDEADBEEF; Done pulses 2 cycles after acceptance; Err=0.
- LB/LBU: addr 0x13, mem_rdata=0x80FF7F01 -> LB gives ReadData=0xFFFFFF80; LBU gives 0x00000080. LH at addr 0x12 -> 0xFFFF80FF; LHU -> 0x000080FF.
- SB: addr 0x21, WriteData=0x123456AB -> mem_addr=0x20, be=0010, wdata=0xABABABAB. SH at 0x22 -> be=1100, wdata=0x56AB56AB. With mem_ready delayed 3 cycles, outputs stay stable throughout and ReadData is unchanged.
- Errors:
  - LW at 0x06 -> no mem_req; Done=Err=1 with ErrCode=01 one cycle after acceptance.
  - funct3=011 load -> ErrCode=10.
  - funct3=011 store at misaligned address 0x05 -> ErrCode=10 (funct3 precedence).
- Timeout: TIMEOUT_CYCLES=16, mem_ready held low -> mem_req high exactly 16 cycles, then Done/Err with ErrCode=11. A following legal LW completes normally with ErrCode=00.
- Reset mid-REQ: rst high on the 2nd REQ cycle -> next cycle mem_req=0, Busy=0, ReadData=0, no Done. MemRead and MemWrite both high with funct3=010 -> treated as load (we=0).
